keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Scans a 4x4 matrix keypad and reports one debounced key code per press, with a one-cycle valid strobe and a held level.
- Input-side counterpart of the multiplexed 4-digit segment display driver: same time-multiplexed column scan, opposite direction.
- Key codes 0-9 feed the display digit inputs directly; codes 10-15 are function keys for upstream control logic.

Parameters:
- SCAN_DIV, 12500: CLK cycles per column slot; minimum 2.
- DEBOUNCE_SCANS, 4: consecutive matching samples required to accept a press or a release; range 1-15.
- REPEAT_DELAY, 250: ticks from accept to first auto-repeat (KEYPAD_REPEAT_EN only).
- REPEAT_PERIOD, 50: ticks between subsequent auto-repeats (KEYPAD_REPEAT_EN only).

Ports:
- CLK  input  1  system clock.
- RST  input  1  synchronous reset, active-high.
- keyRow  input  4  row lines, active-low, pulled up externally; asynchronous to CLK.
- keyCol  output  4  column drive, active-low, exactly one bit low at all times.
- keyCode  output  4  accepted key, row*4 + column index; holds its value until the next accept.
- keyValid  output  1  one-CLK pulse per accepted press or repeat.
- keyHeld  output  1  high while an accepted key is still pressed.

Behaviour:
- Reset values on RST=1 at a CLK edge:
  - keyCol=4'b1110, keyCode=0, keyValid=0, keyHeld=0.
  - State SCAN; all counters 0; synchronizer flops 4'b1111.
  - RST mid-press drops keyHeld immediately; no keyValid is issued.
- Row synchronization: keyRow passes through a 2-flop synchronizer; rs is the synchronized value.
- Tick generation:
  - A divider counts 0..SCAN_DIV-1 and wraps.
  - tick=1 for the single cycle when the count is SCAN_DIV-1.
  - rs is sampled only on tick, at the end of the slot, which gives the lines settling time.
- Row priority: "hit" means rs != 4'b1111. With several rows low, the lowest-index low row wins.
- SCAN state:
  - On tick with no hit, keyCol rotates left by one (1110 -> 1101 -> 1011 -> 0111 -> 1110).
  - On tick with a hit: latch candidate {row,col}, set the debounce count to 1, go to DEBOUNCE. The column does not advance.
- DEBOUNCE state (column frozen):
  - Each tick where the same candidate row is low increments the count.
  - Any tick where it is not low returns to SCAN with count 0; the column advances on that tick.
  - When the count reaches DEBOUNCE_SCANS: keyCode is loaded and keyValid pulses on the next cycle, keyHeld is set, go to HELD.
  - With DEBOUNCE_SCANS=1, accept happens on the detection tick itself.
- HELD state (column frozen):
  - Each tick with the candidate row high increments the release count; a tick with it low clears the count.
  - When the release count reaches DEBOUNCE_SCANS: keyHeld=0, go to SCAN, column advances.
  - A second key pressed while held is ignored; no rollover.
- Latency: a clean press seen at detection tick T gives keyValid in the cycle after tick T+DEBOUNCE_SCANS-1.
- Widths: all counters saturate, never wrap. keyCode = {row[1:0], col[1:0]}.

Optional Feature:
- KEYPAD_REPEAT_EN defined:
  - In HELD, a tick counter starts at accept.
  - keyValid re-pulses, with keyCode unchanged, after REPEAT_DELAY ticks and then every REPEAT_PERIOD ticks until release.
  - A release in progress (release count > 0) suppresses repeats.
- Undefined: exactly one keyValid per press; the repeat counters and parameters are not synthesized.

Decomposition:
- Shared package keypad_pkg:
  - State enum {SCAN, DEBOUNCE, HELD}.
  - COL_RESET=4'b1110, ROWS_IDLE=4'b1111.
  - Key code constants KEY_0..KEY_9, KEY_A..KEY_F.
- One sub-module, scan_tick_gen: the SCAN_DIV divider producing tick. It is reusable by the segment display driver.

Test Plan:
- Bench settings: SCAN_DIV=4, DEBOUNCE_SCANS=3.
- Idle, rows 1111 for 20 ticks -> keyCol cycles 1110,1101,1011,0111,1110...; keyValid never asserts.
- Row 2 held low while keyCol=1101 -> exactly one keyValid pulse, 3 ticks after detection; keyCode=9; keyHeld=1 until 3 released ticks elapse.
- Bounce: row low for 2 ticks, high for 1, then low for 3 -> first attempt aborts; a single keyValid follows the second run.
- Rows 0 and 3 low together on column 2 -> keyCode=2.
- RST asserted while in HELD -> next cycle keyHeld=0, keyCol=1110, no keyValid.
- KEYPAD_REPEAT_EN, REPEAT_DELAY=5, REPEAT_PERIOD=2, key held for 12 ticks after accept -> keyValid at accept and at ticks +5, +7, +9, +11.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types, constants and small helpers for the 4x4 keypad scanner.
// The column/row encodings here also match the multiplexed display driver.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD
    } scanState_e;

    localparam logic [3:0] COL_RESET = 4'b1110;
    localparam logic [3:0] ROWS_IDLE = 4'b1111;

    localparam logic [3:0] KEY_0 = 4'd0;
    localparam logic [3:0] KEY_1 = 4'd1;
    localparam logic [3:0] KEY_2 = 4'd2;
    localparam logic [3:0] KEY_3 = 4'd3;
    localparam logic [3:0] KEY_4 = 4'd4;
    localparam logic [3:0] KEY_5 = 4'd5;
    localparam logic [3:0] KEY_6 = 4'd6;
    localparam logic [3:0] KEY_7 = 4'd7;
    localparam logic [3:0] KEY_8 = 4'd8;
    localparam logic [3:0] KEY_9 = 4'd9;
    localparam logic [3:0] KEY_A = 4'd10;
    localparam logic [3:0] KEY_B = 4'd11;
    localparam logic [3:0] KEY_C = 4'd12;
    localparam logic [3:0] KEY_D = 4'd13;
    localparam logic [3:0] KEY_E = 4'd14;
    localparam logic [3:0] KEY_F = 4'd15;

    // Lowest-index active-low row wins when several rows are pulled down.
    function automatic logic [1:0] lowestLowRow(input logic [3:0] rows);
        logic [1:0] idx;
        if (!rows[0]) begin
            idx = 2'd0;
        end else if (!rows[1]) begin
            idx = 2'd1;
        end else if (!rows[2]) begin
            idx = 2'd2;
        end else begin
            idx = 2'd3;
        end
        return idx;
    endfunction

    function automatic logic [1:0] colIndex(input logic [3:0] col);
        logic [1:0] idx;
        if (!col[0]) begin
            idx = 2'd0;
        end else if (!col[1]) begin
            idx = 2'd1;
        end else if (!col[2]) begin
            idx = 2'd2;
        end else begin
            idx = 2'd3;
        end
        return idx;
    endfunction

    function automatic logic [3:0] rotateCol(input logic [3:0] col);
        return {col[2:0], col[3]};
    endfunction

    function automatic logic [3:0] satInc4(input logic [3:0] value);
        return (value == 4'hF) ? value : value + 4'd1;
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Slot divider: counts 0..DIV-1 and flags the last cycle of each slot.
// Shared by the keypad scanner and the segment display driver.
module scan_tick_gen #(
    parameter int DIV = 12500
) (
    input  logic CLK,
    input  logic RST,
    output logic tick
);

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge CLK) begin
        if (RST) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with debounce, one valid strobe per press and a held level.
// Define KEYPAD_REPEAT_EN to add auto-repeat strobes while a key stays pressed.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 12500,
    parameter int DEBOUNCE_SCANS = 4
`ifdef KEYPAD_REPEAT_EN
    ,
    parameter int REPEAT_DELAY   = 250,
    parameter int REPEAT_PERIOD  = 50
`endif
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] keyRow,
    output logic [3:0] keyCol,
    output logic [3:0] keyCode,
    output logic       keyValid,
    output logic       keyHeld
);

    localparam logic [3:0] DEB_TARGET = 4'(DEBOUNCE_SCANS);
`ifdef KEYPAD_REPEAT_EN
    localparam logic [15:0] REP_DELAY  = 16'(REPEAT_DELAY);
    localparam logic [15:0] REP_PERIOD = 16'(REPEAT_PERIOD);
`endif

    logic       tick;
    logic [3:0] syncA;
    logic [3:0] rs;

    scanState_e state;
    logic [1:0] candRow;
    logic [1:0] candCol;
    logic [3:0] debCnt;
    logic [3:0] relCnt;
`ifdef KEYPAD_REPEAT_EN
    logic [15:0] repCnt;
`endif

    logic       rowHit;
    logic [1:0] hitRow;
    logic       candPressed;

    scan_tick_gen #(
        .DIV(SCAN_DIV)
    ) u_tick (
        .CLK (CLK),
        .RST (RST),
        .tick(tick)
    );

    // Rows are driven by switches with no relation to CLK.
    always_ff @(posedge CLK) begin
        if (RST) begin
            syncA <= ROWS_IDLE;
            rs    <= ROWS_IDLE;
        end else begin
            syncA <= keyRow;
            rs    <= syncA;
        end
    end

    assign rowHit      = (rs != ROWS_IDLE);
    assign hitRow      = lowestLowRow(rs);
    assign candPressed = ~rs[candRow];

    // All decisions happen on tick so the rows have settled for a full slot.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= SCAN;
            keyCol   <= COL_RESET;
            keyCode  <= '0;
            keyValid <= 1'b0;
            keyHeld  <= 1'b0;
            candRow  <= '0;
            candCol  <= '0;
            debCnt   <= '0;
            relCnt   <= '0;
`ifdef KEYPAD_REPEAT_EN
            repCnt   <= '0;
`endif
        end else begin
            keyValid <= 1'b0;
            if (tick) begin
                unique case (state)
                    SCAN: begin
                        if (!rowHit) begin
                            keyCol <= rotateCol(keyCol);
                        end else begin
                            candRow <= hitRow;
                            candCol <= colIndex(keyCol);
                            if (DEB_TARGET <= 4'd1) begin
                                keyCode  <= {hitRow, colIndex(keyCol)};
                                keyValid <= 1'b1;
                                keyHeld  <= 1'b1;
                                debCnt   <= '0;
                                relCnt   <= '0;
                                state    <= HELD;
`ifdef KEYPAD_REPEAT_EN
                                repCnt   <= REP_DELAY;
`endif
                            end else begin
                                debCnt <= 4'd1;
                                state  <= DEBOUNCE;
                            end
                        end
                    end

                    DEBOUNCE: begin
                        if (candPressed) begin
                            if (satInc4(debCnt) >= DEB_TARGET) begin
                                keyCode  <= {candRow, candCol};
                                keyValid <= 1'b1;
                                keyHeld  <= 1'b1;
                                debCnt   <= '0;
                                relCnt   <= '0;
                                state    <= HELD;
`ifdef KEYPAD_REPEAT_EN
                                repCnt   <= REP_DELAY;
`endif
                            end else begin
                                debCnt <= satInc4(debCnt);
                            end
                        end else begin
                            debCnt <= '0;
                            keyCol <= rotateCol(keyCol);
                            state  <= SCAN;
                        end
                    end

                    HELD: begin
                        // Other keys cannot be seen here: the column stays on the held key.
                        if (!candPressed) begin
                            if (satInc4(relCnt) >= DEB_TARGET) begin
                                keyHeld <= 1'b0;
                                relCnt  <= '0;
                                keyCol  <= rotateCol(keyCol);
                                state   <= SCAN;
                            end else begin
                                relCnt <= satInc4(relCnt);
                            end
                        end else begin
                            relCnt <= '0;
                        end
`ifdef KEYPAD_REPEAT_EN
                        // A tick with the row released never repeats, so a release in progress is silent.
                        if (repCnt <= 16'd1) begin
                            repCnt <= REP_PERIOD;
                            if (candPressed) begin
                                keyValid <= 1'b1;
                            end
                        end else begin
                            repCnt <= repCnt - 16'd1;
                        end
`endif
                    end

                    default: begin
                        state <= SCAN;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a key matrix model drives the rows from keyCol,
// and every expected keyValid (code and tick number) goes through a scoreboard queue.
module tb_keypad_scanner;
    import keypad_pkg::*;

    localparam int SCAN_DIV = 4;
    localparam int DS       = 3;
`ifdef KEYPAD_REPEAT_EN
    localparam int EXP_VALIDS = 9;
`else
    localparam int EXP_VALIDS = 4;
`endif

    typedef struct {
        logic [3:0] code;
        int         tickNum;
    } expect_t;

    logic       CLK = 1'b0;
    logic       RST;
    logic [3:0] keyRow;
    logic [3:0] keyCol;
    logic [3:0] keyCode;
    logic       keyValid;
    logic       keyHeld;

    logic [3:0] pressed [4];
    expect_t    sbQueue [$];
    logic [3:0] colSeq  [4];

    int testCount  = 0;
    int failCount  = 0;
    int ticksSeen  = 0;
    int validCount = 0;
    int benchDiv   = 0;

    keypad_scanner #(
        .SCAN_DIV(SCAN_DIV),
        .DEBOUNCE_SCANS(DS)
`ifdef KEYPAD_REPEAT_EN
        ,
        .REPEAT_DELAY(5),
        .REPEAT_PERIOD(2)
`endif
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .keyRow  (keyRow),
        .keyCol  (keyCol),
        .keyCode (keyCode),
        .keyValid(keyValid),
        .keyHeld (keyHeld)
    );

    always #5 CLK = ~CLK;

    // Physical matrix: a pressed key shorts its row to its column when that column is driven low.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            keyRow[r] = ~|(pressed[r] & ~keyCol);
        end
    end

    always @(posedge CLK) begin
        if (RST) begin
            benchDiv <= 0;
        end else if (benchDiv == SCAN_DIV - 1) begin
            benchDiv  <= 0;
            ticksSeen <= ticksSeen + 1;
        end else begin
            benchDiv <= benchDiv + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        assert (obs === exp)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int r, input int c, input logic down);
        pressed[r][c] = down;
    endtask

    task automatic stepTick();
        int t0;
        t0 = ticksSeen;
        while (ticksSeen == t0) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic stepTicks(input int n);
        for (int i = 0; i < n; i++) begin
            stepTick();
        end
    endtask

    always @(negedge CLK) begin
        expect_t e;
        if (RST === 1'b0 && keyValid === 1'b1) begin
            validCount++;
            checkOutput("valid_expected", 32'(sbQueue.size() != 0), 32'd1);
            if (sbQueue.size() != 0) begin
                e = sbQueue.pop_front();
                checkOutput("valid_code", 32'(keyCode), 32'(e.code));
                checkOutput("valid_tick", ticksSeen, e.tickNum);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before 100000 ns");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int b;
        colSeq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        for (int r = 0; r < 4; r++) begin
            pressed[r] = 4'b0000;
        end
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        checkOutput("reset_col", 32'(keyCol), 32'h0000000e);
        checkOutput("reset_code", 32'(keyCode), 32'd0);
        checkOutput("reset_valid", 32'(keyValid), 32'd0);
        checkOutput("reset_held", 32'(keyHeld), 32'd0);
        @(negedge CLK);
        RST = 1'b0;

        // Idle scan: column walks through all four slots.
        for (int k = 1; k <= 20; k++) begin
            stepTick();
            checkOutput("idle_col", 32'(keyCol), 32'(colSeq[k % 4]));
        end
        checkOutput("idle_no_valid", validCount, 0);

        // Single clean press of row 2 / column 1.
        b = ticksSeen;
        applyStimulus(2, 1, 1'b1);
        sbQueue.push_back('{code: 4'd9, tickNum: b + 4});
        stepTicks(4);
        checkOutput("press_code", 32'(keyCode), 32'd9);
        checkOutput("press_held", 32'(keyHeld), 32'd1);
        checkOutput("press_col_frozen", 32'(keyCol), 32'h0000000d);
        stepTicks(2);
        applyStimulus(2, 1, 1'b0);
        stepTicks(2);
        checkOutput("release_still_held", 32'(keyHeld), 32'd1);
        stepTick();
        checkOutput("release_held", 32'(keyHeld), 32'd0);
        checkOutput("release_col", 32'(keyCol), 32'h0000000b);
        checkOutput("press_one_valid", validCount, 1);

        // Bounce on row 1 / column 2: two low ticks, one high, then a clean run.
        b = ticksSeen;
        applyStimulus(1, 2, 1'b1);
        stepTicks(2);
        applyStimulus(1, 2, 1'b0);
        stepTick();
        checkOutput("bounce_abort_held", 32'(keyHeld), 32'd0);
        checkOutput("bounce_abort_col", 32'(keyCol), 32'h00000007);
        applyStimulus(1, 2, 1'b1);
        sbQueue.push_back('{code: 4'd6, tickNum: b + 9});
        stepTicks(6);
        checkOutput("bounce_code", 32'(keyCode), 32'd6);
        checkOutput("bounce_held", 32'(keyHeld), 32'd1);
        applyStimulus(1, 2, 1'b0);
        stepTicks(3);
        checkOutput("bounce_release", 32'(keyHeld), 32'd0);
        checkOutput("bounce_one_valid", validCount, 2);

        // Rows 0 and 3 together on column 2: row 0 has priority.
        b = ticksSeen;
        applyStimulus(0, 2, 1'b1);
        applyStimulus(3, 2, 1'b1);
        sbQueue.push_back('{code: 4'd2, tickNum: b + 6});
        stepTicks(6);
        checkOutput("priority_code", 32'(keyCode), 32'd2);
        applyStimulus(0, 2, 1'b0);
        applyStimulus(3, 2, 1'b0);
        stepTicks(3);
        checkOutput("priority_release", 32'(keyHeld), 32'd0);
        checkOutput("priority_col", 32'(keyCol), 32'h00000007);

        // Reset while a key is held.
        b = ticksSeen;
        applyStimulus(3, 3, 1'b1);
        sbQueue.push_back('{code: 4'd15, tickNum: b + 3});
        stepTicks(4);
        checkOutput("held_code", 32'(keyCode), 32'd15);
        checkOutput("held_before_reset", 32'(keyHeld), 32'd1);
        @(negedge CLK);
        RST = 1'b1;
        applyStimulus(3, 3, 1'b0);
        @(posedge CLK);
        #1;
        checkOutput("rst_held", 32'(keyHeld), 32'd0);
        checkOutput("rst_col", 32'(keyCol), 32'h0000000e);
        checkOutput("rst_valid", 32'(keyValid), 32'd0);
        checkOutput("rst_code", 32'(keyCode), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        stepTicks(4);
        checkOutput("rst_no_new_valid", validCount, 4);

`ifdef KEYPAD_REPEAT_EN
        // Auto-repeat: accept, then +5 and every 2 ticks while held.
        b = ticksSeen;
        applyStimulus(0, 0, 1'b1);
        sbQueue.push_back('{code: 4'd0, tickNum: b + 3});
        sbQueue.push_back('{code: 4'd0, tickNum: b + 8});
        sbQueue.push_back('{code: 4'd0, tickNum: b + 10});
        sbQueue.push_back('{code: 4'd0, tickNum: b + 12});
        sbQueue.push_back('{code: 4'd0, tickNum: b + 14});
        stepTicks(15);
        checkOutput("repeat_held", 32'(keyHeld), 32'd1);
        applyStimulus(0, 0, 1'b0);
        stepTicks(4);
        checkOutput("repeat_release", 32'(keyHeld), 32'd0);
`endif

        checkOutput("sb_drained", sbQueue.size(), 0);
        checkOutput("valid_total", validCount, EXP_VALIDS);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
